// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file.
// Holds the controller state type, the depth helper and the packed-slice index helper.
package regfile_pkg;

  // Controller states: the clear sweep runs in CLEAR, normal operation is IDLE.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Low bit of element 'port' in a packed vector of elements 'width' bits wide.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Selects the addressed entry, forces zero during the clear sweep and for the
// hard-wired zero entry, and forwards same-cycle write data when REGFILE_BYPASS_EN
// is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = depth_of(ADDR_W)
) (
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              clearing,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic byp_hit;

`ifdef REGFILE_BYPASS_EN
  // wr_ok already excludes the clear sweep and dropped zero-entry writes.
  assign byp_hit = wr_ok && (raddr == waddr);
`else
  // Without forwarding the write-port view is not needed here.
  logic unused_wr;
  assign unused_wr = ^{wr_ok, waddr, wdata};
  assign byp_hit   = 1'b0;
`endif

  // Read mux with forwarding and zero masking applied last so masking always wins.
  always_comb begin
    rdata = mem[raddr];
    if (byp_hit) begin
      rdata = wdata;
    end
    if (clearing || ((ZERO_REG != 0) && (raddr == '0))) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a sequential clear sweep.
// After reset (or a clr pulse while idle) every entry is zeroed one per cycle;
// writes are accepted only when wready is high. Read ports are combinational.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     wready,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                clearing;
  logic                wr_ok;

  assign clearing = (state_q == CLEAR);
  assign busy     = clearing;
  assign wready   = !clearing;

  // A host write commits only when idle and not aimed at the hard-wired zero entry.
  assign wr_ok = !clearing && we && !((ZERO_REG != 0) && (waddr == '0));

  // Next-state, sweep pointer and storage write-port selection.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        mem_we = wr_ok;
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // Controller state; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array; contents are only ever zeroed by the sweep, never by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .mem      (mem_q),
      .clearing (clearing),
      .wr_ok    (wr_ok),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr    (raddr[slice_lo(i, ADDR_W) +: ADDR_W]),
      .rdata    (rdata[slice_lo(i, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (default parameters: 32x32, two read ports, zero register).
// Stimulus pushes predicted outputs into a scoreboard queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             wready;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             busy;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wready (wready),
    .raddr  (raddr),
    .rdata  (rdata),
    .busy   (busy)
  );

  typedef struct packed {
    logic             busy;
    logic             wready;
    logic [NR*DW-1:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;

  // Reference model: register contents plus how many sweep cycles remain.
  logic [DW-1:0] regs [DEPTH];
  int            sweep_left;

  function automatic exp_t predict();
    exp_t e;
    e.busy   = (sweep_left > 0);
    e.wready = (sweep_left == 0);
    e.rd     = '0;
    for (int p = 0; p < NR; p++) begin
      int ra;
      logic [DW-1:0] v;
      ra = int'(raddr[p*AW +: AW]);
      if (sweep_left > 0 || ra == 0) v = '0;
      else if (BYP && we && int'(waddr) == ra) v = wdata;
      else v = regs[ra];
      e.rd[p*DW +: DW] = v;
    end
    return e;
  endfunction

  task automatic model_edge();
    if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0) begin
        for (int k = 0; k < DEPTH; k++) regs[k] = '0;
      end
    end else begin
      if (we && waddr != 0) regs[waddr] = wdata;
      if (clr) sweep_left = DEPTH;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input int wa,
                      input logic [DW-1:0] wd, input int ra0, input int ra1);
    rst_n = r;
    clr   = c;
    we    = w;
    waddr = AW'(wa);
    wdata = wd;
    raddr = {AW'(ra1), AW'(ra0)};
    if (!r) sweep_left = DEPTH;
    sb_q.push_back(predict());
    @(posedge clk);
    if (r) model_edge();
    #1;
  endtask

  task automatic rand_step(input logic allow_clr);
    step(1'b1, allow_clr && ($urandom_range(0, 39) == 0), 1'(($urandom_range(0, 1))),
         int'($urandom_range(0, DEPTH-1)), $urandom(),
         int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)));
  endtask

  // Monitor: compare every presented output against the oldest prediction.
  always @(negedge clk) begin
    cyc++;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      vectors++;
      if ({busy, wready, rdata} !== mon_e) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got busy=%b wready=%b rdata=%h, expected busy=%b wready=%b rdata=%h",
                 cyc, busy, wready, rdata, mon_e.busy, mon_e.wready, mon_e.rd);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    we    = 1'b1;
    waddr = AW'(3);
    wdata = 32'h1111_1111;
    raddr = '0;
    sweep_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) regs[k] = '0;
    @(posedge clk);
    #1;

    // Reset held with a pending write, then release: sweep of 32 cycles, write lands after.
    step(1'b0, 1'b0, 1'b1, 3, 32'h1111_1111, 3, 9);
    step(1'b0, 1'b0, 1'b1, 3, 32'h1111_1111, 0, 3);
    for (int i = 0; i < 36; i++)
      step(1'b1, 1'b0, 1'b1, 3, 32'h1111_1111, (i == 20) ? 3 : i % DEPTH, 3);
    step(1'b1, 1'b0, 1'b0, 0, 0, 3, 3);

    // Both ports read the same freshly written entry; zero entry ignores writes.
    step(1'b1, 1'b0, 1'b1, 7, 32'hDEAD_BEEF, 7, 7);
    step(1'b1, 1'b0, 1'b0, 0, 0, 7, 7);
    step(1'b1, 1'b0, 1'b1, 0, 32'h1234_5678, 0, 7);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

    // Fill with index, clear with a concurrent write, keep writing during the sweep.
    for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, i, DW'(i), i, DEPTH - i);
    step(1'b1, 1'b1, 1'b1, 9, 32'h0000_0099, 9, 31);
    for (int i = 0; i < 40; i++) rand_step(1'b0);

    // Fill again, clear, then reset at sweep cycle 10: sweep restarts.
    for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, i, DW'(i * 3), i, 1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 5, 6);
    for (int i = 0; i < 10; i++) rand_step(1'b0);
    step(1'b0, 1'b0, 1'b1, 4, 32'h4444_4444, 4, 5);
    for (int i = 0; i < 40; i++) rand_step(1'b0);

    // Same-cycle read of the entry being written (forwarded only with bypass).
    step(1'b1, 1'b0, 1'b1, 5, 32'hA5A5_A5A5, 0, 5);
    step(1'b1, 1'b0, 1'b0, 0, 0, 5, 5);
    step(1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0);

    // Randomized traffic with occasional clear pulses and rare resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b0, 1'b0, 1'b1, int'($urandom_range(0, DEPTH-1)), $urandom(), 1, 2);
      else
        rand_step(1'b1);
    end

    @(negedge clk);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; next generation of the CPU's 32x32 register file.
- Generalises data width, depth and read-port count.
- Adds a sequential clear sweep (after reset or on request), a busy/ready write handshake, and optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port) of the MIPS datapath.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent read ports (1..4).
- ZERO_REG, 1: 1 = entry 0 is hard-wired to zero (reads 0, writes dropped); 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1: clock; all state updates on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- clr  in  1: synchronous request to start a clear sweep; single-cycle pulse, sampled only in IDLE.
- we  in  1: write enable.
- waddr  in  ADDR_W: write address.
- wdata  in  DATA_W: write data.
- wready  out  1: high when a write is accepted this cycle (IDLE state).
- raddr  in  NUM_RD*ADDR_W: packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W: packed read data; port i at [i*DATA_W +: DATA_W]; combinational from raddr.
- busy  out  1: high while the clear sweep is running.

Behaviour:
- FSM states: CLEAR, IDLE.
- rst_n low, asynchronously: state=CLEAR, sweep pointer ptr=0, busy=1, wready=0. Array contents are not reset asynchronously.
- CLEAR, each rising edge: entry[ptr] <= 0 and ptr <= ptr+1. When ptr==DEPTH-1, the zero is written and the next state is IDLE. The sweep takes exactly DEPTH cycles after rst_n deasserts.
- While in CLEAR:
  - wready=0 and busy=1.
  - we is ignored and the write is dropped; the writer must hold it until wready=1.
  - All rdata ports read 0.
  - clr is ignored.
- IDLE: busy=0, wready=1.
  - we=1 writes wdata to entry[waddr] on the rising edge.
  - If ZERO_REG=1 and waddr==0, the write is dropped.
- IDLE with clr=1: next state CLEAR, ptr=0.
  - A write in the same cycle is still committed, then cleared when the sweep reaches it.
  - clr takes effect on the following edge.
- rdata[i] = entry[raddr[i]], combinational and zero latency.
  - With ZERO_REG=1, raddr[i]==0 always reads 0.
  - Without bypass, a write becomes readable on the cycle after the edge that commits it.
- Multiple read ports may address the same entry; each returns identical data.
- rst_n asserted mid-sweep: the sweep restarts from ptr=0.
- ptr is ADDR_W bits wide; it does not wrap during a sweep because the state exits at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE, if we=1, the write is not dropped, and raddr[i]==waddr, then rdata[i]=wdata in the same cycle (write-first forwarding). Suppressed for entry 0 when ZERO_REG=1, and suppressed in CLEAR.
- Undefined: no forwarding; rdata shows the old value until the next edge.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum (CLEAR, IDLE);
  - localparam helpers: DEPTH from ADDR_W, and the packed-slice index functions.
- One sub-module, regfile_rd_port: a single read mux with zero-register masking and the optional bypass, generated NUM_RD times.
- The storage array and FSM live in the top.

Test Plan:
- Release rst_n, with we=1 held throughout → busy=1 and wready=0 for exactly 32 cycles; every raddr reads 0; the write lands only after wready rises.
- IDLE: write 0xDEADBEEF to entry 7; next cycle raddr0=7, raddr1=7 → both ports return 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to entry 0 → raddr0=0 reads 0x00000000.
- Fill entries 1..31 with their index, pulse clr → busy for 32 cycles, then all reads return 0. Re-assert rst_n at sweep cycle 10 → the sweep restarts and busy lasts 32 more cycles.
- REGFILE_BYPASS_EN defined: we=1, waddr=5, wdata=0xA5A5A5A5, raddr1=5 in the same cycle → rdata1=0xA5A5A5A5 combinationally. Undefined: rdata1 shows the old value (0) that cycle.
- NUM_RD=4, DATA_W=16, ADDR_W=3: write distinct values to entries 1..7 and read 4 different addresses per cycle → each port returns its entry's value; the sweep lasts 8 cycles.
